// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised little-endian RAM behind valid/ready
// request/response channels, with a programmable access latency.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic        l_we;
    logic [2:0]  l_f3;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic [31:0] ram [DEPTH];

    logic          accept_c;
    logic          exec_c;
    logic          err_c;
    logic [AW-1:0] idx_c;
    logic [31:0]   word_c;
    logic [3:0]    be_c;
    logic [31:0]   wlane_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [31:0]   ldata_c;

    assign req_ready = (state == IDLE);
    assign accept_c  = req_valid && req_ready;
    // The access fires on the last WAIT cycle, so RESP is entered LATENCY+1 edges after acceptance.
    assign exec_c    = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(LATENCY);
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - CW'(1);
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fault decode on the latched request: illegal funct3, misalignment, out of range.
    always_comb begin
        logic bad_f3;
        logic misal;
        logic oor;
        bad_f3 = l_we ? (l_f3[2] || (l_f3[1:0] == 2'b11))
                      : ((l_f3[1:0] == 2'b11) || (l_f3 == 3'b110));
        misal  = ((l_f3[1:0] == 2'b01) && l_addr[0]) ||
                 ((l_f3[1:0] == 2'b10) && (l_addr[1:0] != 2'b00));
        oor    = (l_addr[31:2] >= 30'(DEPTH));
        err_c  = bad_f3 || misal || oor;
    end

    assign idx_c  = l_addr[AW+1:2];
    assign word_c = ram[idx_c];

    always_comb begin
        be_c    = 4'b1111;
        wlane_c = l_wdata;
        case (l_f3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << l_addr[1:0];
                wlane_c = {4{l_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = l_addr[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{l_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_c = word_c[7:0];
        case (l_addr[1:0])
            2'd1:    byte_c = word_c[15:8];
            2'd2:    byte_c = word_c[23:16];
            2'd3:    byte_c = word_c[31:24];
            default: ;
        endcase
        half_c  = l_addr[1] ? word_c[31:16] : word_c[15:0];
        ldata_c = word_c;
        case (l_f3[1:0])
            2'b00:   ldata_c = l_f3[2] ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
            2'b01:   ldata_c = l_f3[2] ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
            default: ;
        endcase
    end

    // Request latch, access execution and response hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_we      <= 1'b0;
            l_f3      <= '0;
            l_addr    <= '0;
            l_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
        end else begin
            if (accept_c) begin
                l_we    <= req_we;
                l_f3    <= req_funct3;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
            end
            if (exec_c) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err_c;
                rsp_rdata <= (err_c || l_we) ? 32'd0 : ldata_c;
                if (!err_c && l_we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be_c[i]) ram[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
                    end
                end
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed, stall, throughput,
// randomized and mid-transaction reset scenarios against a byte-array model.
module tb_data_mem_responder;

    localparam int unsigned LAT  = 2;
    localparam int unsigned NB   = 1024;
    localparam int          TMO  = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [NB];

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        e;
    } op_t;

    localparam op_t DIR [16] = '{
        '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0},
        '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0},
        '{1'b1, 3'b000, 32'h11,  32'h000000AA, 32'h0,        1'b0},
        '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADAAEF, 1'b0},
        '{1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFAA, 1'b0},
        '{1'b0, 3'b100, 32'h11,  32'h0,        32'h000000AA, 1'b0},
        '{1'b1, 3'b001, 32'h12,  32'h00008001, 32'h0,        1'b0},
        '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8001, 1'b0},
        '{1'b0, 3'b101, 32'h12,  32'h0,        32'h00008001, 1'b0},
        '{1'b0, 3'b010, 32'h10,  32'h0,        32'h8001AAEF, 1'b0},
        '{1'b0, 3'b010, 32'h13,  32'h0,        32'h0,        1'b1},
        '{1'b1, 3'b001, 32'h11,  32'h0000BEEF, 32'h0,        1'b1},
        '{1'b0, 3'b010, 32'h10,  32'h0,        32'h8001AAEF, 1'b0},
        '{1'b0, 3'b010, 32'h400, 32'h0,        32'h0,        1'b1},
        '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1},
        '{1'b1, 3'b100, 32'h10,  32'h00001234, 32'h0,        1'b1}
    };

    data_mem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < int'(NB); i++) mem[i] = 8'h00;
    endtask

    // Byte-level reference: legality, alignment, range, then little-endian access.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int          n;
        int          base;
        logic        legal;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n     = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        e     = !legal || ((a % 32'(n)) != 32'd0) || (a >= 32'(NB));
        rd    = 32'd0;
        if (!e) begin
            base = int'(a);
            if (we) begin
                for (int i = 0; i < n; i++) mem[base + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem[base + i];
                if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
                rd = v;
            end
        end
    endtask

    // One full transaction; returns response and edges from acceptance to rsp_valid.
    task automatic drive_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic e,
                             output int cyc);
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!rsp_valid && cyc < TMO);
        rd = rsp_rdata;
        e  = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] rd, mrd;
        logic        e, me;
        int          cyc;
        for (int i = 0; i < 16; i++) begin
            drive_txn(DIR[i].we, DIR[i].f3, DIR[i].a, DIR[i].wd, rd, e, cyc);
            model(DIR[i].we, DIR[i].f3, DIR[i].a, DIR[i].wd, mrd, me);
            total++; if (cyc !== int'(LAT) + 1) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, LAT + 1); end
            total++; if (rd !== DIR[i].rd) begin bad++; $display("FAIL dir%0d_rdata: got %h want %h", i, rd, DIR[i].rd); end
            total++; if (e !== DIR[i].e) begin bad++; $display("FAIL dir%0d_err: got %b want %b", i, e, DIR[i].e); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp1, exp2;
        logic        e1, e2;
        int          cyc;
        model(1'b0, 3'b010, 32'h10, 32'd0, exp1, e1);
        model(1'b0, 3'b010, 32'h14, 32'd0, exp2, e2);
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 32'h14;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!rsp_valid && cyc < TMO);
        total++; if (cyc !== int'(LAT) + 1) begin bad++; $display("FAIL stall_latency: got %0d want %0d", cyc, LAT + 1); end
        for (int k = 0; k < 5; k++) begin
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d: got %b want 1", k, rsp_valid); end
            total++; if (rsp_rdata !== exp1) begin bad++; $display("FAIL stall_rdata%0d: got %h want %h", k, rsp_rdata, exp1); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_req_ready%0d: got %b want 0", k, req_ready); end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_drop: got %b want 0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_idle_after_hs: got %b want 1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!rsp_valid && cyc < TMO);
        total++; if (cyc !== int'(LAT) + 1) begin bad++; $display("FAIL stall_second_latency: got %0d want %0d", cyc, LAT + 1); end
        total++; if (rsp_rdata !== exp2) begin bad++; $display("FAIL stall_second_rdata: got %h want %h", rsp_rdata, exp2); end
        total++; if (rsp_err !== e2) begin bad++; $display("FAIL stall_second_err: got %b want %b", rsp_err, e2); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        logic        e;
        int          hs = 0;
        model(1'b0, 3'b010, 32'h10, 32'd0, exp, e);
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4 * (int'(LAT) + 3); i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                hs++;
                total++; if (rsp_rdata !== exp) begin bad++; $display("FAIL b2b_rdata%0d: got %h want %h", hs, rsp_rdata, exp); end
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        total++; if (hs !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", hs); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_end_idle: got %b want 1", req_ready); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, mrd;
        logic [2:0]  f3;
        logic        we, e, me;
        int          cyc, r;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            wd = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(NB) + $urandom_range(0, 15);
            else if (r < 7)  a = $urandom_range(0, 63);
            else             a = $urandom_range(0, NB - 1);
            drive_txn(we, f3, a, wd, rd, e, cyc);
            model(we, f3, a, wd, mrd, me);
            total++; if (cyc !== int'(LAT) + 1) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, cyc, LAT + 1); end
            total++; if (rd !== mrd) begin bad++; $display("FAIL rnd%0d_rdata: we=%b f3=%b a=%h got %h want %h", i, we, f3, a, rd, mrd); end
            total++; if (e !== me) begin bad++; $display("FAIL rnd%0d_err: we=%b f3=%b a=%h got %b want %b", i, we, f3, a, e, me); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        e;
        int          cyc;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp: got %b want 0", rsp_valid); end
        drive_txn(1'b0, 3'b010, 32'h20, 32'd0, rd, e, cyc);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL rstmid_lw20: got %h want 00000000", rd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL rstmid_lw20_err: got %b want 0", e); end
        drive_txn(1'b0, 3'b010, 32'h10, 32'd0, rd, e, cyc);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL rstmid_lw10: got %h want 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
